range_line_fetcher: RTL

- Upstream feeder for the element read buffer in the PageRank datapath.
- Accepts an element-index range [start,end) over an array of WIDTH-bit elements at a base address.
- Issues one FULL_WIDTH-bit line read per cache line covering the range, and hands each returned line to the read buffer with per-line base/bounds element offsets.
- Keeps one line prefetched while the buffer drains the previous line.

---
 rtl/range_line_fetcher.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/range_line_fetcher.sv
// Range line fetcher: walks an element range [start,end) one cache line at a time,
// keeps one line prefetched, and loads each line into the read buffer with base/bounds offsets.
module range_line_fetcher #(
  parameter int FULL_WIDTH = 512,
  parameter int WIDTH      = 64,
  parameter int ADDR_W     = 64,
  parameter int IDX_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IDX_W-1:0]      req_start,
  input  logic [IDX_W-1:0]      req_end,
  input  logic [ADDR_W-1:0]     req_base_addr,
  output logic                  mem_rd_valid,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_resp_valid,
  input  logic [FULL_WIDTH-1:0] mem_resp_data,
  output logic                  buf_rready,
  output logic [FULL_WIDTH-1:0] buf_rdata,
  output logic [7:0]            buf_base,
  output logic [7:0]            buf_bounds,
  input  logic                  buf_oready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            o_dbg_state
);

  localparam int E     = FULL_WIDTH / WIDTH;
  localparam int E_SH  = $clog2(E);
  localparam int LB_SH = $clog2(FULL_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_cur_line;
  logic [IDX_W-1:0]      r_first_line;
  logic [IDX_W-1:0]      r_last_line;
  logic [IDX_W-1:0]      r_start_off;
  logic [IDX_W-1:0]      r_end;
  logic [ADDR_W-1:0]     r_base_addr;
  logic                  r_out_valid;
  logic [IDX_W-1:0]      r_out_line;
  logic                  r_hold_valid;
  logic [IDX_W-1:0]      r_hold_line;
  logic [FULL_WIDTH-1:0] r_hold_data;
  logic                  r_push_prev;
  logic                  r_last_pushed;

  logic                  w_accept;
  logic                  w_empty;
  logic                  w_lines_left;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_mem_hs;
  logic                  w_capture;
  logic [ADDR_W-1:0]     w_line_addr;
  logic [IDX_W-1:0]      w_base_full;
  logic [IDX_W-1:0]      w_bounds_full;

  // Handshakes: a request transfers on req_valid && req_ready, a line read on
  // mem_rd_valid && mem_rd_ready; mem_rd_valid/addr never change while waiting for ready.
  assign w_accept     = req_valid && req_ready;
  assign w_empty      = (req_end <= req_start);
  assign w_lines_left = (r_cur_line <= r_last_line);

  // The buffer raises buf_oready one cycle after a load, so the cycle after a push is skipped.
  assign w_push    = (r_state == S_RUN) && r_hold_valid && !buf_oready && !r_push_prev;
  assign w_issue   = (r_state == S_RUN) && w_lines_left && !r_out_valid &&
                     (!r_hold_valid || w_push);
  assign w_mem_hs  = w_issue && mem_rd_ready;
  assign w_capture = mem_resp_valid && r_out_valid;

  assign w_line_addr   = r_base_addr + (ADDR_W'(r_cur_line) << LB_SH);
  assign w_base_full   = (r_hold_line == r_first_line) ? r_start_off : '0;
  assign w_bounds_full = (r_hold_line == r_last_line) ?
                         (r_end - (r_hold_line << E_SH)) : IDX_W'(E);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_empty ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_last_pushed && !r_push_prev && !buf_oready) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cur_line    <= '0;
      r_first_line  <= '0;
      r_last_line   <= '0;
      r_start_off   <= '0;
      r_end         <= '0;
      r_base_addr   <= '0;
      r_out_valid   <= 1'b0;
      r_out_line    <= '0;
      r_hold_valid  <= 1'b0;
      r_hold_line   <= '0;
      r_hold_data   <= '0;
      r_push_prev   <= 1'b0;
      r_last_pushed <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_push_prev <= w_push;
      if (w_accept) begin
        r_cur_line    <= req_start >> E_SH;
        r_first_line  <= req_start >> E_SH;
        r_last_line   <= (req_end - IDX_W'(1)) >> E_SH;
        r_start_off   <= req_start & IDX_W'(E - 1);
        r_end         <= req_end;
        r_base_addr   <= req_base_addr;
        r_out_valid   <= 1'b0;
        r_hold_valid  <= 1'b0;
        r_last_pushed <= 1'b0;
      end else begin
        if (w_capture) begin
          r_out_valid <= 1'b0;
        end
        if (w_mem_hs) begin
          r_cur_line  <= r_cur_line + IDX_W'(1);
          r_out_valid <= 1'b1;
          r_out_line  <= r_cur_line;
        end
        // A capture may coincide with a push; the new line then refills the hold.
        if (w_capture) begin
          r_hold_valid <= 1'b1;
          r_hold_line  <= r_out_line;
          r_hold_data  <= mem_resp_data;
        end else if (w_push) begin
          r_hold_valid <= 1'b0;
        end
        if (w_push && (r_hold_line == r_last_line)) begin
          r_last_pushed <= 1'b1;
        end
      end
    end
  end

  assign req_ready    = (r_state == S_IDLE) && !rst;
  assign mem_rd_valid = w_issue;
  assign mem_rd_addr  = w_issue ? w_line_addr : '0;
  assign buf_rready   = w_push;
  assign buf_rdata    = w_push ? r_hold_data : '0;
  assign buf_base     = w_push ? w_base_full[7:0] : 8'd0;
  assign buf_bounds   = w_push ? w_bounds_full[7:0] : 8'd0;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign o_dbg_state  = r_state;

endmodule
